// File: rtl/sum_collector_pkg.sv
// -----------------------------------------------------------------------------
// sum_collector_pkg
// Shared definitions for the sum collector: the packed result entry, default
// sizing and the pointer-width helper used by the FIFO and the interface.
// -----------------------------------------------------------------------------
package sum_collector_pkg;

    localparam int ENTRY_W       = 5;
    localparam int DEPTH_DEF     = 4;
    localparam int OVF_CNT_W_DEF = 8;

    // One captured adder result: carry-out on top, 4-bit sum below.
    typedef struct packed {
        logic       ovf;
        logic [3:0] sum;
    } entry_t;

    // Read/write pointer width for a FIFO of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sum_collector_if.sv
// -----------------------------------------------------------------------------
// sum_collector_if
// Bundles the adder-side capture inputs and the consumer-side handshake and
// status outputs of sum_collector.
//   slave  : the collector (inputs En/Clr/Sum/Overflow/Out_Ready, drives the rest)
//   master : the environment (adder, controller and consumer)
// -----------------------------------------------------------------------------
interface sum_collector_if
    import sum_collector_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int OVF_CNT_W = OVF_CNT_W_DEF
);

    localparam int LVL_W = ptr_w(DEPTH) + 1;

    logic                 En;
    logic                 Clr;
    logic [3:0]           Sum;
    logic                 Overflow;
    logic                 Out_Ready;
    logic                 Out_Valid;
    logic [3:0]           Out_Sum;
    logic                 Out_Ovf;
    logic [LVL_W-1:0]     Level;
    logic [OVF_CNT_W-1:0] Ovf_Count;
    logic                 Drop;

    modport slave (
        input  En, Clr, Sum, Overflow, Out_Ready,
        output Out_Valid, Out_Sum, Out_Ovf, Level, Ovf_Count, Drop
    );

    modport master (
        output En, Clr, Sum, Overflow, Out_Ready,
        input  Out_Valid, Out_Sum, Out_Ovf, Level, Ovf_Count, Drop
    );

endinterface

// File: rtl/sum_collector_fifo.sv
// -----------------------------------------------------------------------------
// sum_fifo
// Generic synchronous first-word-fall-through FIFO with explicit level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (overrides push and pop)
//   push, din  : write request and data
//   pop        : read request; ignored when empty
//   dout       : head entry, forced to 0 when empty
//   level      : occupancy 0..DEPTH
//   full/empty : status flags
// A push while full is accepted only if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module sum_fifo
    import sum_collector_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [ptr_w(DEPTH):0]   level,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    assign do_pop  = pop & ~empty & ~clr;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & ~clr & (~full | do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        level_d = level_q;
        if (clr) begin
            rd_d    = '0;
            wr_d    = '0;
            level_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; its contents are only visible when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rd_q];
    assign level = level_q;

endmodule

// File: rtl/sum_collector.sv
// -----------------------------------------------------------------------------
// sum_collector
// Downstream stage of the 4-bit operand adder. One cycle after each enabled
// operand load the adder result {Overflow, Sum} is captured into a FWFT FIFO
// that is drained through a valid/ready handshake.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   bus.En      : operand-load enable of the adder (delayed here to capture)
//   bus.Clr     : synchronous flush of FIFO and statistics
//   bus.Sum/Overflow       : adder outputs
//   bus.Out_Valid/Out_Ready: output handshake, Out_Sum/Out_Ovf = head entry
//   bus.Level   : FIFO occupancy
//   bus.Ovf_Count: saturating count of captures with Overflow=1
//   bus.Drop    : sticky, set when a capture was lost to a full FIFO
// -----------------------------------------------------------------------------
module sum_collector
    import sum_collector_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int OVF_CNT_W = OVF_CNT_W_DEF
) (
    input  logic           Clk,
    input  logic           Rst_n,
    sum_collector_if.slave bus
);

    localparam int LVL_W = ptr_w(DEPTH) + 1;
    localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

    logic                 en_q, en_d;
    logic                 drop_q, drop_d;
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

    logic                 capture;
    logic                 pop;
    logic                 valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    entry_t               push_e;
    entry_t               head_e;

    // The adder registers its operands on the En edge, so its result is
    // stable for the following cycle and is taken on the next edge.
    assign en_d    = bus.Clr ? 1'b0 : bus.En;
    assign capture = en_q & ~bus.Clr;
    assign push_e  = '{ovf: bus.Overflow, sum: bus.Sum};

    assign valid   = ~fifo_empty;
    assign pop     = valid & bus.Out_Ready;

    sum_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (bus.Clr),
        .push  (capture),
        .pop   (pop),
        .din   (push_e),
        .dout  (head_e),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        drop_d = drop_q;
        cnt_d  = cnt_q;
        if (bus.Clr) begin
            drop_d = 1'b0;
            cnt_d  = '0;
        end else begin
            if (capture && fifo_full && !pop) drop_d = 1'b1;
            // Dropped captures still count toward the overflow statistic.
            if (capture && bus.Overflow && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            en_q   <= 1'b0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            en_q   <= en_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Out_Valid = valid;
    assign bus.Out_Sum   = head_e.sum;
    assign bus.Out_Ovf   = head_e.ovf;
    assign bus.Level     = fifo_level;
    assign bus.Ovf_Count = cnt_q;
    assign bus.Drop      = drop_q;

endmodule

// File: tb/tb_sum_collector.sv
// -----------------------------------------------------------------------------
// tb_sum_collector
// Directed bench for sum_collector. Two instances share the clock, reset and a
// small adder model: dut (DEPTH=4, OVF_CNT_W=8) and dut2 (OVF_CNT_W=2) for the
// counter saturation case. Expected FIFO entries are queued when a load is
// driven and compared when popped from the DUT.
// -----------------------------------------------------------------------------
module tb_sum_collector;

    logic Clk;
    logic Rst_n;
    logic [3:0] A, B;
    logic [3:0] a_q, b_q;
    logic [4:0] add_w;

    int checks;
    int errors;
    logic [4:0] sb [$];

    sum_collector_if #(.DEPTH(4), .OVF_CNT_W(8)) ifc ();
    sum_collector_if #(.DEPTH(4), .OVF_CNT_W(2)) ifc2 ();

    sum_collector #(.DEPTH(4), .OVF_CNT_W(8)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (ifc.slave)
    );

    sum_collector #(.DEPTH(4), .OVF_CNT_W(2)) dut2 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (ifc2.slave)
    );

    // Upstream adder: operands registered on En, combinational sum/carry.
    always_ff @(posedge Clk) begin
        if (ifc.En || ifc2.En) begin
            a_q <= A;
            b_q <= B;
        end
    end
    assign add_w         = {1'b0, a_q} + {1'b0, b_q};
    assign ifc.Sum       = add_w[3:0];
    assign ifc.Overflow  = add_w[4];
    assign ifc2.Sum      = add_w[3:0];
    assign ifc2.Overflow = add_w[4];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [4:0] exp_entry(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [3:0] a, input logic [3:0] b);
        ifc.En = en;
        A = a;
        B = b;
        tick();
    endtask

    // Compare the head against the scoreboard, then pop it with one Ready cycle.
    task automatic pop_chk(input string tag);
        logic [4:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(ifc.Out_Valid), 32'd1);
            chk({tag, "_sum"}, 32'(ifc.Out_Sum), 32'(e[3:0]));
            chk({tag, "_ovf"}, 32'(ifc.Out_Ovf), 32'(e[4]));
            ifc.Out_Ready = 1'b1;
            tick();
            ifc.Out_Ready = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        A = '0;
        B = '0;
        ifc.En = 0;  ifc.Clr = 0;  ifc.Out_Ready = 0;
        ifc2.En = 0; ifc2.Clr = 0; ifc2.Out_Ready = 0;

        // Reset state
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", 32'(ifc.Out_Valid), 32'd0);
        chk("rst_level", 32'(ifc.Level), 32'd0);
        chk("rst_sum", 32'(ifc.Out_Sum), 32'd0);
        chk("rst_ovf", 32'(ifc.Out_Ovf), 32'd0);
        chk("rst_cnt", 32'(ifc.Ovf_Count), 32'd0);
        chk("rst_drop", 32'(ifc.Drop), 32'd0);
        Rst_n = 1'b1;
        tick();

        // Single load 3+4: visible two edges after En, not one
        step(1, 3, 4);
        sb.push_back(exp_entry(3, 4));
        chk("single_lat1_valid", 32'(ifc.Out_Valid), 32'd0);
        step(0, 0, 0);
        chk("single_level", 32'(ifc.Level), 32'd1);
        chk("single_sum", 32'(ifc.Out_Sum), 32'd7);
        pop_chk("single_pop");
        chk("single_level_after_pop", 32'(ifc.Level), 32'd0);
        // Pop on empty is ignored
        ifc.Out_Ready = 1'b1;
        tick();
        ifc.Out_Ready = 1'b0;
        chk("pop_empty_level", 32'(ifc.Level), 32'd0);
        chk("pop_empty_valid", 32'(ifc.Out_Valid), 32'd0);

        // Back-to-back overflow loads 9+9, 15+1, 2+2
        step(1, 9, 9);   sb.push_back(exp_entry(9, 9));
        chk("b2b_level0", 32'(ifc.Level), 32'd0);
        step(1, 15, 1);  sb.push_back(exp_entry(15, 1));
        chk("b2b_level1", 32'(ifc.Level), 32'd1);
        step(1, 2, 2);   sb.push_back(exp_entry(2, 2));
        chk("b2b_level2", 32'(ifc.Level), 32'd2);
        step(0, 0, 0);
        chk("b2b_level3", 32'(ifc.Level), 32'd3);
        chk("b2b_ovf_count", 32'(ifc.Ovf_Count), 32'd2);
        pop_chk("b2b_pop0");
        pop_chk("b2b_pop1");
        pop_chk("b2b_pop2");
        chk("b2b_empty", 32'(ifc.Level), 32'd0);

        // Fill and drop: sums 1..5 with Out_Ready low
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 4'(i));
            if (i <= 4) sb.push_back(exp_entry(0, 4'(i)));
            chk("fill_level", 32'(ifc.Level), 32'(i - 1));
        end
        chk("fill_drop_before", 32'(ifc.Drop), 32'd0);
        step(0, 0, 0);
        chk("fill_level_full", 32'(ifc.Level), 32'd4);
        chk("fill_drop", 32'(ifc.Drop), 32'd1);
        step(0, 0, 0);
        chk("fill_head_stable", 32'(ifc.Out_Sum), 32'd1);
        chk("fill_valid_stable", 32'(ifc.Out_Valid), 32'd1);
        pop_chk("fill_pop_first");
        chk("fill_level_3", 32'(ifc.Level), 32'd3);

        // Clr with Level=3, Drop=1, a pending capture and En in the same cycle
        step(1, 0, 7);
        chk("clr_pre_level", 32'(ifc.Level), 32'd3);
        ifc.Clr = 1'b1;
        step(1, 0, 8);
        ifc.Clr = 1'b0;
        chk("clr_level", 32'(ifc.Level), 32'd0);
        chk("clr_valid", 32'(ifc.Out_Valid), 32'd0);
        chk("clr_drop", 32'(ifc.Drop), 32'd0);
        chk("clr_cnt", 32'(ifc.Ovf_Count), 32'd0);
        chk("clr_sum", 32'(ifc.Out_Sum), 32'd0);
        step(0, 0, 0);
        chk("clr_no_late_level", 32'(ifc.Level), 32'd0);
        chk("clr_no_late_valid", 32'(ifc.Out_Valid), 32'd0);
        sb.delete();

        // Full with simultaneous pop and capture
        for (int i = 5; i <= 8; i++) begin
            step(1, 0, 4'(i));
            sb.push_back(exp_entry(0, 4'(i)));
        end
        step(0, 0, 0);
        chk("fullpop_pre_level", 32'(ifc.Level), 32'd4);
        step(1, 0, 9);
        sb.push_back(exp_entry(0, 9));
        chk("fullpop_head", 32'(ifc.Out_Sum), 32'(sb[0][3:0]));
        void'(sb.pop_front());
        ifc.Out_Ready = 1'b1;
        step(0, 0, 0);
        ifc.Out_Ready = 1'b0;
        chk("fullpop_level", 32'(ifc.Level), 32'd4);
        chk("fullpop_drop", 32'(ifc.Drop), 32'd0);
        pop_chk("fullpop_drain0");
        pop_chk("fullpop_drain1");
        pop_chk("fullpop_drain2");
        pop_chk("fullpop_drain3");
        chk("fullpop_empty", 32'(ifc.Level), 32'd0);

        // Saturation on the 2-bit counter: five 8+8 loads
        for (int i = 0; i <= 5; i++) begin
            ifc2.En = (i < 5);
            A = 4'd8;
            B = 4'd8;
            tick();
            if (i >= 1) chk("sat_cnt", 32'(ifc2.Ovf_Count), 32'((i > 3) ? 3 : i));
        end
        ifc2.En = 1'b0;
        chk("sat_drop", 32'(ifc2.Drop), 32'd1);
        chk("sat_level", 32'(ifc2.Level), 32'd4);

        // Asynchronous reset mid-stream with a capture pending
        step(1, 15, 15);
        step(1, 1, 1);
        chk("arst_pre_level", 32'(ifc.Level), 32'd1);
        chk("arst_pre_cnt", 32'(ifc.Ovf_Count), 32'd1);
        ifc.En = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(ifc.Level), 32'd0);
        chk("arst_valid", 32'(ifc.Out_Valid), 32'd0);
        chk("arst_sum", 32'(ifc.Out_Sum), 32'd0);
        chk("arst_ovf", 32'(ifc.Out_Ovf), 32'd0);
        chk("arst_cnt", 32'(ifc.Ovf_Count), 32'd0);
        chk("arst_drop2", 32'(ifc2.Drop), 32'd0);
        chk("arst_level2", 32'(ifc2.Level), 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();
        chk("arst_no_late_level", 32'(ifc.Level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
